// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multicycle load/store sequencer with read-modify-write for sub-word stores
// Optional misalignment trap: define MISALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SW = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_LB = 3'b011;
  localparam logic [2:0] OP_LW = 3'b100;
  localparam logic [2:0] OP_LH = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       load_data_q, load_data_d;
`ifdef MISALIGN_TRAP_EN
  logic              trap_q, trap_d;
`endif

  // Big-endian lanes: byte k lives at [31-8k -: 8], halfword h at [31-16h -: 16].
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] put_half(input logic [31:0] w, input logic h,
                                           input logic [15:0] v);
    return h ? {w[31:16], v} : {v, w[15:0]};
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] o,
                                          input logic [1:0] a);
    logic [31:0] r;
    case (o)
      OP_LB:   r = {24'b0, get_byte(w, a)};
      OP_LH:   r = {16'b0, (a[1] ? w[15:0] : w[31:16])};
      default: r = w;
    endcase
    return r;
  endfunction

  logic cmd_is_load;
  logic cmd_is_sub;
  logic q_is_load;

  always_comb begin
    cmd_is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    cmd_is_sub  = (op == OP_SB) || (op == OP_SH);
    q_is_load   = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
    trap_d      = trap_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          data_d = st_data;
`ifdef MISALIGN_TRAP_EN
          trap_d = 1'b0;
`endif
          if (cmd_is_load || cmd_is_sub) begin
            state_d = S_RD;
          end else if (op == OP_SW) begin
            state_d = S_WR;
          end else begin
            state_d = S_DONE;
          end
`ifdef MISALIGN_TRAP_EN
          if ((((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) ||
              (((op == OP_LH) || (op == OP_SH)) && addr[0])) begin
            trap_d  = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RD: begin
        cnt_d   = 2'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rd_d = mem_rdata;
          if (q_is_load) begin
            load_data_d = extract(mem_rdata, op_q, addr_q[1:0]);
            state_d     = S_DONE;
          end else begin
            state_d = S_WR;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b0;
      addr_q      <= '0;
      data_q      <= 32'b0;
      rd_q        <= 32'b0;
      cnt_q       <= 2'b0;
      load_data_q <= 32'b0;
`ifdef MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
`ifdef MISALIGN_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_rd    = (state_q == S_RD);
    mem_wr    = (state_q == S_WR);
    mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    load_data = load_data_q;
    mem_wdata = 32'b0;
    if (state_q == S_WR) begin
      case (op_q)
        OP_SB:   mem_wdata = put_byte(rd_q, addr_q[1:0], data_q[7:0]);
        OP_SH:   mem_wdata = put_half(rd_q, addr_q[1], data_q[15:0]);
        default: mem_wdata = data_q;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign err = (state_q == S_DONE) && trap_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int LAT = 1;
  localparam logic [2:0] SB = 3'd0, SW = 3'd1, SH = 3'd2, LB = 3'd3, LW = 3'd4, LH = 3'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  mem_access_ctrl #(.ADDR_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr), .st_data(st_data),
    .busy(busy), .done(done), .load_data(load_data), .err(err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:63];
  logic [31:0] pipe [0:3];
  always @(posedge clk) begin
    pipe[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct {int cyc; logic [31:0] ld; logic er; int nrd; int nwr;} done_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  done_t exp_done[$];
  wr_t   exp_wr[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a write or a done pulse.
  int rd_cnt = 0;
  int wr_cnt = 0;
  initial begin
    done_t e;
    wr_t   w;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (!reset_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
        chk("reset_ctl", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
      end else begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            chk("unexpected_mem_wr", 32'd1, 32'd0);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr, w.a);
            chk("wr_data", mem_wdata, w.d);
          end
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_done.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("load_data", load_data, e.ld);
            chk("err", {31'd0, err}, {31'd0, e.er});
            chk("rd_count", rd_cnt, e.nrd);
            chk("wr_count", wr_cnt, e.nwr);
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       input int lat, input logic [31:0] ld, input logic er, input int nrd,
                       input int nwr, input logic [31:0] wd, input int hold);
    wait_idle();
    op = o;
    addr = a;
    st_data = d;
    start = 1'b1;
    exp_done.push_back('{cyc + lat, ld, er, nrd, nwr});
    if (nwr != 0) exp_wr.push_back('{{a[31:2], 2'b00}, wd});
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    //     op  addr   st_data        lat ld             er nrd nwr wdata          hold
    issue(SW, 32'h10, 32'hAABBCCDD, 2, 32'h00000000, 0, 0, 1, 32'hAABBCCDD, 1);
    issue(LW, 32'h10, 32'h0,        3, 32'hAABBCCDD, 0, 1, 0, 32'h0,        1);
    issue(SW, 32'h10, 32'h11223344, 2, 32'hAABBCCDD, 0, 0, 1, 32'h11223344, 1);
    issue(SB, 32'h13, 32'h000000EE, 4, 32'hAABBCCDD, 0, 1, 1, 32'h112233EE, 1);
    issue(SW, 32'h10, 32'h11223344, 2, 32'hAABBCCDD, 0, 0, 1, 32'h11223344, 1);
    issue(SH, 32'h10, 32'h0000BEEF, 4, 32'hAABBCCDD, 0, 1, 1, 32'hBEEF3344, 1);
    issue(LH, 32'h12, 32'h0,        3, 32'h00003344, 0, 1, 0, 32'h0,        1);
    issue(LB, 32'h11, 32'h0,        3, 32'h000000EF, 0, 1, 0, 32'h0,        1);
    issue(LB, 32'h10, 32'h0,        3, 32'h000000BE, 0, 1, 0, 32'h0,        1);
    issue(SH, 32'h12, 32'h1234ABCD, 4, 32'h000000BE, 0, 1, 1, 32'hBEEFABCD, 1);
    issue(LH, 32'h10, 32'h0,        3, 32'h0000BEEF, 0, 1, 0, 32'h0,        1);
    issue(SB, 32'h11, 32'hFFFFFF5A, 4, 32'h0000BEEF, 0, 1, 1, 32'hBE5AABCD, 1);
    issue(LW, 32'h10, 32'h0,        3, 32'hBE5AABCD, 0, 1, 0, 32'h0,        1);
    issue(SW, 32'h20, 32'hCAFEF00D, 2, 32'hBE5AABCD, 0, 0, 1, 32'hCAFEF00D, 3);
    issue(LW, 32'h20, 32'h0,        3, 32'hCAFEF00D, 0, 1, 0, 32'h0,        1);
    issue(3'b110, 32'h10, 32'h0,    1, 32'hCAFEF00D, 0, 0, 0, 32'h0,        1);
    issue(3'b111, 32'h24, 32'h0,    1, 32'hCAFEF00D, 0, 0, 0, 32'h0,        1);

    // Abort an sb in WAIT; nothing may be written after release.
    wait_idle();
    op = SB;
    addr = 32'h10;
    st_data = 32'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(LW, 32'h10, 32'h0, 3, 32'hBE5AABCD, 0, 1, 0, 32'h0, 1);
`ifdef MISALIGN_TRAP_EN
    issue(LW, 32'h11, 32'h0,        1, 32'hBE5AABCD, 1, 0, 0, 32'h0, 1);
    issue(SH, 32'h13, 32'h00009999, 1, 32'hBE5AABCD, 1, 0, 0, 32'h0, 1);
    issue(LB, 32'h13, 32'h0,        3, 32'h000000CD, 0, 1, 0, 32'h0, 1);
`else
    issue(LW, 32'h11, 32'h0,        3, 32'hBE5AABCD, 0, 1, 0, 32'h0,        1);
    issue(SH, 32'h13, 32'h00009999, 4, 32'hBE5AABCD, 0, 1, 1, 32'hBE5A9999, 1);
    issue(LB, 32'h13, 32'h0,        3, 32'h00000099, 0, 1, 0, 32'h0,        1);
`endif

    wait_idle();
    repeat (5) @(negedge clk);
    chk("done_queue_drained", exp_done.size(), 32'd0);
    chk("wr_queue_drained", exp_wr.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
